// File: rtl/dco_cal_pkg.sv
// Shared types and helpers for the DCO coarse-band SAR calibration.
// Optional tracking loop is enabled with DCO_CAL_TRACK_EN (see dco_coarse_cal).
package dco_cal_pkg;

  localparam int DCO_DCTRL_WIDTH = 9;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_MEASURE,
    ST_DECIDE,
    ST_DONE,
    ST_TRACK
  } cal_state_t;

  // Mid-scale code: only the MSB set, the first SAR trial.
  function automatic int unsigned mid_code(input int unsigned width);
    return 32'd1 << (width - 1);
  endfunction

endpackage

// File: rtl/dco_cal_freq_meas.sv
// Windowed CKV edge counter: accumulates modular deltas of the retimed
// free-running CKV count over 2**WIN_LOG2 reference cycles.
module dco_cal_freq_meas #(
  parameter int CNT_W    = 10,
  parameter int WIN_LOG2 = 6
) (
  input  logic                      clk,
  input  logic                      srst,
  input  logic                      clear,
  input  logic                      meas_en,
  input  logic [CNT_W-1:0]          ckv_cnt,
  output logic                      win_done,
  output logic [CNT_W+WIN_LOG2-1:0] acc
);

  localparam int ACC_W = CNT_W + WIN_LOG2;

  logic [CNT_W-1:0]    prev_reg;
  logic [ACC_W-1:0]    acc_reg;
  logic [WIN_LOG2-1:0] win_cnt_reg;
  logic [CNT_W-1:0]    delta;

  // Modular subtraction absorbs counter wrap between samples.
  assign delta    = ckv_cnt - prev_reg;
  assign win_done = meas_en && (win_cnt_reg == '1);
  assign acc      = acc_reg;

  always_ff @(posedge clk) begin
    if (srst) begin
      prev_reg    <= '0;
      acc_reg     <= '0;
      win_cnt_reg <= '0;
    end else if (clear) begin
      prev_reg    <= ckv_cnt;
      acc_reg     <= '0;
      win_cnt_reg <= '0;
    end else if (meas_en) begin
      prev_reg    <= ckv_cnt;
      acc_reg     <= acc_reg + {{WIN_LOG2{1'b0}}, delta};
      win_cnt_reg <= win_cnt_reg + 1'b1;
    end
  end

endmodule

// File: rtl/dco_coarse_cal.sv
// SAR band-select calibration of the V/DCO coarse code against a target FCW.
// Define DCO_CAL_TRACK_EN to keep nudging DCTRL by +/-1 after lock.
module dco_coarse_cal
  import dco_cal_pkg::*;
#(
  parameter int DCTRL_W    = DCO_DCTRL_WIDTH,
  parameter int CNT_W      = 10,
  parameter int FCW_W      = 16,
  parameter int FRAC_W     = 8,
  parameter int WIN_LOG2   = 6,
  parameter int SETTLE_CYC = 16
) (
  input  logic                                        CLK,
  input  logic                                        RST,
  input  logic                                        START,
  input  logic [FCW_W-1:0]                            FCW_Q,
  input  logic [CNT_W-1:0]                            CKV_CNT,
  output logic [DCTRL_W-1:0]                          DCTRL,
  output logic                                        BUSY,
  output logic                                        DONE,
  output logic                                        CAL_SAT,
  output logic signed [CNT_W+WIN_LOG2+FRAC_W:0]       CAL_ERR
);

  localparam int ACC_W = CNT_W + WIN_LOG2;
  localparam int ERR_W = ACC_W + FRAC_W + 1;
  localparam int SET_W = $clog2(SETTLE_CYC + 1);
  localparam int IDX_W = $clog2(DCTRL_W + 1);
  localparam logic [DCTRL_W-1:0] MID = DCTRL_W'(mid_code(DCTRL_W));

  cal_state_t              state_reg, state_next;
  logic [SET_W-1:0]        settle_cnt_reg;
  logic [IDX_W-1:0]        idx_reg;
  logic [FCW_W-1:0]        fcw_reg;
  logic [DCTRL_W-1:0]      dctrl_reg;
  logic signed [ERR_W-1:0] cal_err_reg;
  logic                    cal_sat_reg;
  logic                    tracking;

  logic                    settle_last, start_ok, win_done, keep;
  logic [ACC_W-1:0]        acc;
  logic [ERR_W-1:0]        meas_scaled, tgt_scaled;
  logic signed [ERR_W-1:0] meas_err;
  logic [DCTRL_W-1:0]      bit_mask, dctrl_kept, dctrl_trial;

  assign settle_last = (settle_cnt_reg == SET_W'(SETTLE_CYC - 1));
  assign start_ok    = START && (state_reg == ST_IDLE || state_reg == ST_DONE || tracking);

  dco_cal_freq_meas #(
    .CNT_W    (CNT_W),
    .WIN_LOG2 (WIN_LOG2)
  ) u_freq_meas (
    .clk      (CLK),
    .srst     (RST),
    .clear    (state_reg == ST_SETTLE && settle_last),
    .meas_en  (state_reg == ST_MEASURE),
    .ckv_cnt  (CKV_CNT),
    .win_done (win_done),
    .acc      (acc)
  );

  // Both sides scaled to edges per window in FRAC_W fixed point.
  assign meas_scaled = {1'b0, acc, {FRAC_W{1'b0}}};
  assign tgt_scaled  = ERR_W'({fcw_reg, {WIN_LOG2{1'b0}}});
  assign meas_err    = signed'(meas_scaled - tgt_scaled);
  assign keep        = meas_err[ERR_W-1] || (meas_err == '0);

  assign bit_mask    = DCTRL_W'(1) << idx_reg;
  assign dctrl_kept  = keep ? dctrl_reg : (dctrl_reg & ~bit_mask);
  assign dctrl_trial = (idx_reg != '0) ? (dctrl_kept | (bit_mask >> 1)) : dctrl_kept;

`ifdef DCO_CAL_TRACK_EN
  localparam logic signed [ERR_W-1:0] BAND = ERR_W'(1) << (WIN_LOG2 + FRAC_W - 1);
  logic tracking_reg;
  assign tracking = tracking_reg;
`else
  assign tracking = 1'b0;
`endif

  always_ff @(posedge CLK) begin
    if (RST) state_reg <= ST_IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    if (start_ok) begin
      state_next = ST_SETTLE;
    end else begin
      case (state_reg)
        ST_SETTLE:  if (settle_last) state_next = ST_MEASURE;
        ST_MEASURE: if (win_done) state_next = tracking ? ST_TRACK : ST_DECIDE;
        ST_DECIDE:  state_next = (idx_reg == '0) ? ST_DONE : ST_SETTLE;
`ifdef DCO_CAL_TRACK_EN
        ST_DONE:    state_next = ST_SETTLE;
        ST_TRACK:   state_next = ST_SETTLE;
`endif
        default:    state_next = state_reg;
      endcase
    end
  end

  always_comb begin
    BUSY = !tracking && (state_reg == ST_SETTLE || state_reg == ST_MEASURE ||
                         state_reg == ST_DECIDE);
    DONE = (state_reg == ST_DONE) || tracking;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      settle_cnt_reg <= '0;
      idx_reg        <= IDX_W'(DCTRL_W - 1);
      fcw_reg        <= '0;
      dctrl_reg      <= MID;
      cal_err_reg    <= '0;
      cal_sat_reg    <= 1'b0;
`ifdef DCO_CAL_TRACK_EN
      tracking_reg   <= 1'b0;
`endif
    end else if (start_ok) begin
      settle_cnt_reg <= '0;
      idx_reg        <= IDX_W'(DCTRL_W - 1);
      fcw_reg        <= FCW_Q;
      dctrl_reg      <= MID;
`ifdef DCO_CAL_TRACK_EN
      tracking_reg   <= 1'b0;
`endif
    end else begin
      case (state_reg)
        ST_SETTLE: settle_cnt_reg <= settle_last ? '0 : settle_cnt_reg + 1'b1;
        ST_DECIDE: begin
          cal_err_reg <= meas_err;
          dctrl_reg   <= dctrl_trial;
          if (idx_reg != '0) idx_reg <= idx_reg - 1'b1;
          else cal_sat_reg <= (dctrl_kept == '0) || (dctrl_kept == '1);
        end
`ifdef DCO_CAL_TRACK_EN
        ST_DONE:   tracking_reg <= 1'b1;
        ST_TRACK: begin
          cal_err_reg <= meas_err;
          if (meas_err > BAND && dctrl_reg != '0)
            dctrl_reg <= dctrl_reg - 1'b1;
          else if (meas_err < -BAND && dctrl_reg != '1)
            dctrl_reg <= dctrl_reg + 1'b1;
        end
`endif
        default: ;
      endcase
    end
  end

  assign DCTRL   = dctrl_reg;
  assign CAL_SAT = cal_sat_reg;
  assign CAL_ERR = cal_err_reg;

endmodule
